// File: rtl/vidtiming.sv
// vidtiming: parametrised raster timing generator and pixel source.
// Produces registered DE/HSYNC/VSYNC/SOF and pixel data for one raster
// fixed at elaboration. Line/frame order: active, front porch, sync, back porch.
// Optional build macro VIDTIMING_PATTERN_EN adds the test-pattern sources
// (ramp, colour bars, checkerboard) selected by `mode`; without it the
// output is always the external `pix` stream.
module vidtiming #(
  parameter int unsigned HACT  = 1280,
  parameter int unsigned HFP   = 110,
  parameter int unsigned HSYNC = 40,
  parameter int unsigned HBP   = 220,
  parameter int unsigned VACT  = 720,
  parameter int unsigned VFP   = 5,
  parameter int unsigned VSYNC = 5,
  parameter int unsigned VBP   = 20,
  parameter int unsigned HSPOL = 1,
  parameter int unsigned VSPOL = 1,
  parameter int unsigned CW    = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic [3*CW-1:0] pix,
  output logic            pixreq,
  output logic            de,
  output logic            hs,
  output logic            vs,
  output logic [3*CW-1:0] dat,
  output logic            sof
);

  localparam int unsigned HTOT = HACT + HFP + HSYNC + HBP;
  localparam int unsigned VTOT = VACT + VFP + VSYNC + VBP;
  localparam int unsigned HW   = $clog2(HTOT);
  localparam int unsigned VW   = $clog2(VTOT);
  localparam logic        HS_ON = (HSPOL != 0);
  localparam logic        VS_ON = (VSPOL != 0);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [VW-1:0]     vcnt_q, vcnt_d;
  logic              de_q, de_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic              sof_q, sof_d;
  logic [3*CW-1:0]   dat_q, dat_d;

  int unsigned       hi, vi;
  logic              run, h_last, v_last, frame_first, active;

`ifdef VIDTIMING_PATTERN_EN
  localparam int unsigned BW  = (HACT / 8 > 0) ? HACT / 8 : 1;
  localparam int unsigned BSW = (BW > 1) ? $clog2(BW) : 1;

  logic [1:0]        mode_q, mode_d;
  logic [2:0]        bar_idx_q, bar_idx_d;
  logic [BSW-1:0]    bar_sub_q, bar_sub_d;
  logic [1:0]        cur_mode;
  logic [3*CW-1:0]   pat;
`else
  logic              unused_mode;
  assign unused_mode = ^mode;
`endif

  // Raster counters, FSM next state and next registered outputs.
  always_comb begin
    hi          = 32'(hcnt_q);
    vi          = 32'(vcnt_q);
    run         = (state_q == S_RUN);
    h_last      = (hi == HTOT - 1);
    v_last      = (vi == VTOT - 1);
    frame_first = run && (hi == 0) && (vi == 0);
    active      = run && (hi < HACT) && (vi < VACT);

    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    case (state_q)
      S_IDLE: begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (en) state_d = S_RUN;
      end
      S_RUN: begin
        if (h_last) begin
          hcnt_d = '0;
          if (v_last) begin
            vcnt_d = '0;
            // Leaving RUN is only allowed at the frame's last pixel.
            if (!en) state_d = S_IDLE;
          end else begin
            vcnt_d = vcnt_q + 1'b1;
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    de_d  = active;
    sof_d = frame_first;
    hs_d  = (run && hi >= HACT + HFP && hi < HACT + HFP + HSYNC) ? HS_ON : !HS_ON;
    vs_d  = (run && vi >= VACT + VFP && vi < VACT + VFP + VSYNC) ? VS_ON : !VS_ON;

`ifdef VIDTIMING_PATTERN_EN
    // The frame's first pixel already uses the freshly sampled mode.
    cur_mode = frame_first ? mode : mode_q;
    mode_d   = cur_mode;

    // Bar index tracks hcnt via a sub-counter; it saturates at 7 so the
    // last bar absorbs any HACT remainder.
    bar_idx_d = bar_idx_q;
    bar_sub_d = bar_sub_q;
    if (!run || h_last) begin
      bar_idx_d = '0;
      bar_sub_d = '0;
    end else if (bar_idx_q != 3'd7) begin
      if (bar_sub_q == BSW'(BW - 1)) begin
        bar_idx_d = bar_idx_q + 1'b1;
        bar_sub_d = '0;
      end else begin
        bar_sub_d = bar_sub_q + 1'b1;
      end
    end

    case (cur_mode)
      2'd0:    pat = pix;
      2'd1:    pat = {3{hi[CW-1:0]}};
      2'd2:    pat = {{CW{~bar_idx_q[1]}}, {CW{~bar_idx_q[2]}}, {CW{~bar_idx_q[0]}}};
      default: pat = {(3*CW){hi[4] ^ vi[4]}};
    endcase

    pixreq = active && (cur_mode == 2'd0);
    dat_d  = active ? pat : '0;
`else
    pixreq = active;
    dat_d  = active ? pix : '0;
`endif
  end

  // State, counters and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      de_q      <= 1'b0;
      hs_q      <= !HS_ON;
      vs_q      <= !VS_ON;
      sof_q     <= 1'b0;
      dat_q     <= '0;
`ifdef VIDTIMING_PATTERN_EN
      mode_q    <= '0;
      bar_idx_q <= '0;
      bar_sub_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      de_q      <= de_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      sof_q     <= sof_d;
      dat_q     <= dat_d;
`ifdef VIDTIMING_PATTERN_EN
      mode_q    <= mode_d;
      bar_idx_q <= bar_idx_d;
      bar_sub_q <= bar_sub_d;
`endif
    end
  end

  assign de  = de_q;
  assign hs  = hs_q;
  assign vs  = vs_q;
  assign sof = sof_q;
  assign dat = dat_q;

endmodule
